restricted_seq_scheduler: RTL and testbench
===========================================

RESTRICTED_SEQ_SCHEDULER -- requirements
Module: restricted_seq_scheduler

Interface
REQ-001 Parameter SEED, default 13'h1ACE: LFSR reset/reload value; SHALL be nonzero.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level; leave IDLE and begin sequencing.
REQ-005 stop  input  1  level; return to IDLE, discard buffered symbols.
REQ-006 seed_load / seed  input  1 / 13  load LFSR, honoured in IDLE only.
REQ-007 prob  input  3  head-placement probability; captured on IDLE->PRIME.
REQ-008 gen_random / gen_restricted / gen_prob  output  13 / 2 / 3  drive restricted-move generator: LFSR state, restricted symbol, captured prob.
REQ-009 gen_seq  input  8  combinational generator result; symbol k in bits [2k+1:2k], k=0 emitted first.
REQ-010 sym_valid / sym  output  1 / 2  symbol stream; sym_ready  input  1  consumer ready.
REQ-011 block_cnt  output  16  completed 4-symbol blocks since reset; wraps 16'hFFFF->0.

Function
REQ-012 FSM states IDLE, PRIME, RUN; stop has priority over start and overrides every state -> IDLE next cycle.
REQ-013 IDLE: sym_valid=0; start=1 -> PRIME; seed_load=1 loads seed, or SEED when seed==0.
REQ-014 PRIME (exactly 1 cycle): gen_restricted=last_sym; cur<=gen_seq; idx<=0; LFSR steps; -> RUN.
REQ-015 RUN: sym_valid=1, sym=cur[2*idx+1:2*idx]; sym and sym_valid SHALL be registered-stable while sym_ready=0.
REQ-016 RUN, handshake (sym_valid&sym_ready): last_sym<=sym; if idx<3 idx increments, else cur<=nxt, idx<=0, nxt_valid<=0, block_cnt increments.
REQ-017 RUN, nxt_valid==0 and no swap this cycle: gen_restricted=cur[7:6]; nxt<=gen_seq; nxt_valid<=1; LFSR steps.
REQ-018 Swap SHALL never find nxt_valid==0; output SHALL have zero bubbles between blocks under continuous sym_ready.
REQ-019 First sym_valid SHALL assert 2 cycles after start is sampled in IDLE.
REQ-020 LFSR: 13-bit Fibonacci, shift left, feedback q[12]^q[3]^q[2]^q[0]; steps only on generator captures (REQ-014/017); state never 0.
REQ-021 stop mid-block: cur/nxt contents discarded (nxt_valid<=0, idx<=0); last_sym, LFSR, block_cnt retained.
REQ-022 gen_restricted SHALL equal last_sym outside RUN; gen_prob SHALL hold captured prob until next PRIME.

Reset
REQ-023 On rst_n=0: state=IDLE, lfsr=SEED, cur=nxt=0, idx=0, nxt_valid=0, last_sym=0, gen_prob=0, block_cnt=0, sym_valid=0, sym=0.
REQ-024 Reset asserted mid-RUN SHALL drop sym_valid asynchronously; no handshake completes in that cycle.

Structure
REQ-025 Package seq_pkg holds: state enum (IDLE, PRIME, RUN), SYM_W=2, BLK_W=8, RND_W=13, LFSR tap constant.
REQ-026 One sub-module seq_lfsr13 (clk, rst_n, step, load, load_val, q); generator instantiated outside this block.
REQ-027 Target 150-300 lines RTL; no multi-cycle paths; gen_seq path SHALL close timing combinationally within one cycle.

Verification
REQ-028 Reset, no stimulus -> all outputs per REQ-023, gen_random==13'h1ACE.
REQ-029 seed_load=1, seed=0 in IDLE -> gen_random==SEED; seed=13'h0005 -> gen_random==13'h0005; seed_load during RUN -> ignored.
REQ-030 start, sym_ready=1, prob=0, 40 cycles -> sym_valid rises cycle 2, never falls; every 4-symbol group a permutation of {0,1,2,3}; every group ends with symbol 0; block_cnt==9 after 38 handshakes.
REQ-031 RUN, sym_ready toggled randomly -> sym stable while ready=0; emitted stream identical to ready=1 run from same seed.
REQ-032 stop after 6 handshakes -> sym_valid=0 next cycle, block_cnt==1, last_sym==6th symbol; restart -> first block generated with gen_restricted==that symbol.
REQ-033 rst_n pulsed low mid-block -> sym_valid=0 immediately; on release state IDLE, block_cnt==0.

Source files
------------

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the restricted symbol scheduler.
//   state_e    : scheduler FSM states (IDLE, PRIME, RUN)
//   SYM_W      : width of one symbol
//   BLK_W      : width of one 4-symbol block (symbol k in bits [2k+1:2k])
//   RND_W      : width of the LFSR handed to the generator
//   LFSR_TAPS  : feedback tap mask (bits 12, 3, 2, 0)
//   blk_sym()  : extracts symbol idx from a packed block
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam int SYM_W = 2;
    localparam int BLK_W = 8;
    localparam int RND_W = 13;
    localparam int IDX_W = 2;
    localparam int CNT_W = 16;

    localparam logic [RND_W-1:0] LFSR_TAPS = 13'h100D;

    function automatic logic [SYM_W-1:0] blk_sym(input logic [BLK_W-1:0] blk,
                                                 input logic [IDX_W-1:0] idx);
        return blk[idx*SYM_W +: SYM_W];
    endfunction

endpackage

// File: rtl/seq_lfsr13.sv
// ---------------------------------------------------------------------------
// seq_lfsr13
// 13-bit Fibonacci LFSR, shifting left with the XOR of the tapped bits
// entering at bit 0. Advances only when step is high; load has priority.
// The update is a bijection, so a nonzero state can never reach zero.
//   clk, rst_n : clock, asynchronous active-low reset (state <- RESET_VAL)
//   step       : advance one position
//   load       : replace state with load_val (caller guarantees nonzero)
//   load_val   : value to load
//   q          : current state
// ---------------------------------------------------------------------------
module seq_lfsr13
    import seq_pkg::*;
#(
    parameter logic [RND_W-1:0] RESET_VAL = 13'h1ACE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [RND_W-1:0] load_val,
    output logic [RND_W-1:0] q
);

    logic [RND_W-1:0] lfsr_d;
    logic [RND_W-1:0] lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (step) begin
            lfsr_d = {lfsr_q[RND_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/restricted_seq_scheduler.sv
// ---------------------------------------------------------------------------
// restricted_seq_scheduler
// Drives an external combinational restricted-move generator and streams its
// 4-symbol blocks out over a valid/ready handshake. While the current block
// (cur) is being emitted, the following block (nxt) is prefetched so blocks
// follow each other with no bubbles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, stop         : level controls; stop wins and forces IDLE
//   seed_load, seed     : reload the LFSR in IDLE (seed==0 reloads SEED)
//   prob                : head-placement probability, captured on IDLE->PRIME
//   gen_random          : LFSR state presented to the generator
//   gen_restricted      : symbol the generator must not lead with
//   gen_prob            : captured prob presented to the generator
//   gen_seq             : generator result, symbol k in bits [2k+1:2k]
//   sym_valid, sym      : registered output symbol stream
//   sym_ready           : consumer ready
//   block_cnt           : completed 4-symbol blocks since reset (wrapping)
// ---------------------------------------------------------------------------
module restricted_seq_scheduler
    import seq_pkg::*;
#(
    parameter logic [RND_W-1:0] SEED = 13'h1ACE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             seed_load,
    input  logic [RND_W-1:0] seed,
    input  logic [2:0]       prob,
    output logic [RND_W-1:0] gen_random,
    output logic [SYM_W-1:0] gen_restricted,
    output logic [2:0]       gen_prob,
    input  logic [BLK_W-1:0] gen_seq,
    output logic             sym_valid,
    output logic [SYM_W-1:0] sym,
    input  logic             sym_ready,
    output logic [CNT_W-1:0] block_cnt
);

    state_e           state_q, state_d;
    logic [BLK_W-1:0] cur_q, cur_d;
    logic [BLK_W-1:0] nxt_q, nxt_d;
    logic             nxt_valid_q, nxt_valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SYM_W-1:0] last_sym_q, last_sym_d;
    logic [2:0]       prob_q, prob_d;
    logic [CNT_W-1:0] block_cnt_q, block_cnt_d;
    logic             sym_valid_q, sym_valid_d;
    logic [SYM_W-1:0] sym_q, sym_d;

    logic             lfsr_step;
    logic             lfsr_load;
    logic [RND_W-1:0] lfsr_load_val;
    logic             handshake;
    logic             swap;

    // A zero seed would lock the LFSR, so it falls back to SEED.
    assign lfsr_load     = (state_q == IDLE) && seed_load;
    assign lfsr_load_val = (seed == '0) ? SEED : seed;

    seq_lfsr13 #(
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (lfsr_step),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .q        (gen_random)
    );

    // In RUN the only generator capture is the prefetch of nxt, which must
    // avoid leading with the last symbol of cur.
    assign gen_restricted = (state_q == RUN) ? cur_q[BLK_W-1 -: SYM_W] : last_sym_q;

    assign handshake = (state_q == RUN) && sym_valid_q && sym_ready && !stop;
    assign swap      = handshake && (idx_q == IDX_W'(3));

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        nxt_valid_d = nxt_valid_q;
        idx_d       = idx_q;
        last_sym_d  = last_sym_q;
        prob_d      = prob_q;
        block_cnt_d = block_cnt_q;
        lfsr_step   = 1'b0;

        if (stop) begin
            state_d     = IDLE;
            cur_d       = '0;
            nxt_d       = '0;
            nxt_valid_d = 1'b0;
            idx_d       = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = PRIME;
                        prob_d  = prob;
                    end
                end
                PRIME: begin
                    cur_d     = gen_seq;
                    idx_d     = '0;
                    lfsr_step = 1'b1;
                    state_d   = RUN;
                end
                RUN: begin
                    if (handshake) begin
                        last_sym_d = sym_q;
                        if (swap) begin
                            cur_d       = nxt_q;
                            idx_d       = '0;
                            nxt_valid_d = 1'b0;
                            block_cnt_d = block_cnt_q + CNT_W'(1);
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    // Prefetch lands a full block ahead of the swap, so the
                    // swap always finds nxt valid.
                    if (!nxt_valid_q && !swap) begin
                        nxt_d       = gen_seq;
                        nxt_valid_d = 1'b1;
                        lfsr_step   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        sym_valid_d = (state_d == RUN);
        sym_d       = blk_sym(cur_d, idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            nxt_q       <= '0;
            nxt_valid_q <= 1'b0;
            idx_q       <= '0;
            last_sym_q  <= '0;
            prob_q      <= '0;
            block_cnt_q <= '0;
            sym_valid_q <= 1'b0;
            sym_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            nxt_valid_q <= nxt_valid_d;
            idx_q       <= idx_d;
            last_sym_q  <= last_sym_d;
            prob_q      <= prob_d;
            block_cnt_q <= block_cnt_d;
            sym_valid_q <= sym_valid_d;
            sym_q       <= sym_d;
        end
    end

    assign gen_prob  = prob_q;
    assign sym_valid = sym_valid_q;
    assign sym       = sym_q;
    assign block_cnt = block_cnt_q;

endmodule

// File: tb/tb_restricted_seq_scheduler.sv
// ---------------------------------------------------------------------------
// tb_restricted_seq_scheduler
// Directed sequence with randomized ready, checked against a block-level
// reference: each block k of a session is generator(L_k, restriction_k, prob)
// where L_k is the LFSR k steps past the session's starting value and the
// restriction is the last symbol of the previous block (or last_sym for the
// first block). The bench also plays the external generator.
// ---------------------------------------------------------------------------
module tb_restricted_seq_scheduler;

    localparam logic [12:0] SEED = 13'h1ACE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        seed_load = 1'b0;
    logic [12:0] seed = '0;
    logic [2:0]  prob = '0;
    logic [12:0] gen_random;
    logic [1:0]  gen_restricted;
    logic [2:0]  gen_prob;
    logic [7:0]  gen_seq;
    logic        sym_valid;
    logic [1:0]  sym;
    logic        sym_ready = 1'b0;
    logic [15:0] block_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Stand-in restricted-move generator: permutation of {0,1,2,3}; symbol 0
    // goes to the head with probability prob/8, otherwise to the tail; the
    // block never leads with the restricted symbol.
    function automatic logic [7:0] gen_fn(input logic [12:0] r, input logic [1:0] s,
                                          input logic [2:0] p);
        logic [1:0] a0, a1, a2, t;
        logic       head0;
        case (r[2:0] % 3'd6)
            3'd0:    begin a0 = 2'd1; a1 = 2'd2; a2 = 2'd3; end
            3'd1:    begin a0 = 2'd1; a1 = 2'd3; a2 = 2'd2; end
            3'd2:    begin a0 = 2'd2; a1 = 2'd1; a2 = 2'd3; end
            3'd3:    begin a0 = 2'd2; a1 = 2'd3; a2 = 2'd1; end
            3'd4:    begin a0 = 2'd3; a1 = 2'd1; a2 = 2'd2; end
            default: begin a0 = 2'd3; a1 = 2'd2; a2 = 2'd1; end
        endcase
        head0 = (r[5:3] < p) && (s != 2'd0);
        if (!head0 && a0 == s) begin
            t = a0; a0 = a1; a1 = t;
        end
        if (head0) return {a2, a1, a0, 2'd0};
        return {2'd0, a2, a1, a0};
    endfunction

    assign gen_seq = gen_fn(gen_random, gen_restricted, gen_prob);

    restricted_seq_scheduler #(.SEED(SEED)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .seed_load      (seed_load),
        .seed           (seed),
        .prob           (prob),
        .gen_random     (gen_random),
        .gen_restricted (gen_restricted),
        .gen_prob       (gen_prob),
        .gen_seq        (gen_seq),
        .sym_valid      (sym_valid),
        .sym            (sym),
        .sym_ready      (sym_ready),
        .block_cnt      (block_cnt)
    );

    // ---------------- reference model ----------------
    logic [12:0] lfsr_m;
    logic [1:0]  last_m;
    logic [1:0]  tail_m;
    logic [2:0]  prob_m;
    logic [15:0] cnt_m;
    logic [1:0]  q_m[$];
    int          hs_in_blk;

    function automatic logic [12:0] lfsr_next(input logic [12:0] x);
        return {x[11:0], x[12] ^ x[3] ^ x[2] ^ x[0]};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_gen_block();
        logic [7:0] blk;
        blk = gen_fn(lfsr_m, tail_m, prob_m);
        for (int k = 0; k < 4; k++) q_m.push_back(blk[2*k +: 2]);
        tail_m = blk[7:6];
        lfsr_m = lfsr_next(lfsr_m);
    endtask

    task automatic m_session_start();
        q_m.delete();
        hs_in_blk = 0;
        tail_m = last_m;
        m_gen_block();
        m_gen_block();
    endtask

    task automatic m_handshake(input logic [1:0] s);
        logic [1:0] e;
        e = q_m.pop_front();
        check("sym", {14'd0, s}, {14'd0, e});
        last_m = e;
        hs_in_blk++;
        if (hs_in_blk == 4) begin
            hs_in_blk = 0;
            cnt_m++;
            m_gen_block();
        end
    endtask

    task automatic m_reset();
        lfsr_m = SEED;
        last_m = '0;
        cnt_m  = '0;
        q_m.delete();
        hs_in_blk = 0;
    endtask

    // Starts a session from IDLE: checks the PRIME cycle, then the first valid.
    task automatic do_start(input logic [2:0] p);
        prob = p;
        prob_m = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("prime_valid", {15'd0, sym_valid}, 16'd0);
        check("prime_restricted", {14'd0, gen_restricted}, {14'd0, last_m});
        check("gen_prob", {13'd0, gen_prob}, {13'd0, p});
        m_session_start();
        @(negedge clk);
        check("first_valid", {15'd0, sym_valid}, 16'd1);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        sym_ready = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        q_m.delete();
        hs_in_blk = 0;
        check("stop_valid", {15'd0, sym_valid}, 16'd0);
        check("stop_block_cnt", block_cnt, cnt_m);
        check("stop_last_sym", {14'd0, gen_restricted}, {14'd0, last_m});
        check("stop_lfsr", {3'd0, gen_random}, {3'd0, lfsr_m});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] grp_mask;
        logic [1:0] held;
        bit         hold;
        int         hs;
        int         cyc;

        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_valid", {15'd0, sym_valid}, 16'd0);
        check("rst_sym", {14'd0, sym}, 16'd0);
        check("rst_block_cnt", block_cnt, 16'd0);
        check("rst_random", {3'd0, gen_random}, {3'd0, SEED});
        check("rst_restricted", {14'd0, gen_restricted}, 16'd0);
        check("rst_prob", {13'd0, gen_prob}, 16'd0);

        // Seed loading in IDLE.
        seed_load = 1'b1;
        seed = 13'h0005;
        @(negedge clk);
        check("seed_5", {3'd0, gen_random}, 16'h0005);
        seed = 13'h0000;
        @(negedge clk);
        check("seed_zero", {3'd0, gen_random}, {3'd0, SEED});
        seed_load = 1'b0;
        lfsr_m = SEED;

        // Continuous-ready run, prob=0; seed_load pulsed mid-run must be ignored.
        sym_ready = 1'b1;
        do_start(3'd0);
        grp_mask = '0;
        for (int i = 0; i < 38; i++) begin
            check("run1_valid", {15'd0, sym_valid}, 16'd1);
            seed_load = (i == 20);
            seed = 13'h0077;
            grp_mask = grp_mask | (4'd1 << sym);
            if (i % 4 == 3) begin
                check("run1_perm", {12'd0, grp_mask}, 16'h000F);
                check("run1_tail0", {14'd0, sym}, 16'd0);
                grp_mask = '0;
            end
            m_handshake(sym);
            @(negedge clk);
        end
        seed_load = 1'b0;
        check("run1_block_cnt", block_cnt, cnt_m);
        do_stop();

        // Random-ready run from reloaded seed, prob=3.
        seed_load = 1'b1;
        seed = 13'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        lfsr_m = SEED;
        check("reload_seed", {3'd0, gen_random}, {3'd0, SEED});
        sym_ready = 1'b0;
        do_start(3'd3);
        hs = 0;
        cyc = 0;
        hold = 1'b0;
        held = '0;
        while (hs < 42 && cyc < 600) begin
            if (hold) begin
                check("hold_valid", {15'd0, sym_valid}, 16'd1);
                check("hold_sym", {14'd0, sym}, {14'd0, held});
            end
            sym_ready = 1'($urandom_range(0, 1));
            if (sym_valid && sym_ready) begin
                m_handshake(sym);
                hs++;
                hold = 1'b0;
            end else begin
                hold = sym_valid;
                held = sym;
            end
            cyc++;
            @(negedge clk);
        end
        check("run2_budget", 16'(hs), 16'd42);
        check("run2_block_cnt", block_cnt, cnt_m);
        do_stop();

        // Asynchronous reset mid-block.
        sym_ready = 1'b1;
        do_start(3'd0);
        for (int i = 0; i < 5; i++) begin
            m_handshake(sym);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1 check("rst_async_valid", {15'd0, sym_valid}, 16'd0);
        m_reset();
        sym_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_block_cnt", block_cnt, 16'd0);
        check("rst_mid_random", {3'd0, gen_random}, {3'd0, SEED});
        @(negedge clk);
        check("rst_mid_idle", {15'd0, sym_valid}, 16'd0);

        // Stop after 6 handshakes, then restart restricted by the 6th symbol.
        sym_ready = 1'b1;
        do_start(3'd0);
        for (int i = 0; i < 6; i++) begin
            m_handshake(sym);
            @(negedge clk);
        end
        do_stop();
        check("stop6_block_cnt", block_cnt, 16'd1);
        sym_ready = 1'b1;
        do_start(3'd0);
        for (int i = 0; i < 8; i++) begin
            check("restart_valid", {15'd0, sym_valid}, 16'd1);
            m_handshake(sym);
            @(negedge clk);
        end
        check("restart_block_cnt", block_cnt, cnt_m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
